// File: rtl/ddma_mem_arbiter_pkg.sv
// Shared types and constants for the double-DMA memory port arbiter.
package ddma_mem_arbiter_pkg;

  localparam int ARB_MEM_W             = 32;
  localparam int ARB_MAX_BURST_DEFAULT = 16;

  typedef logic [ARB_MEM_W-1:0] memword;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_RECV = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/ddma_mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_pick2
  import ddma_mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  arb_owner_t i_last_served,
  output arb_owner_t o_winner
);

  // Winner selection; bit 0 is SEND, bit 1 is RECV.
  always_comb begin
    o_winner = ARB_IDLE;
    case (i_req)
      2'b01:   o_winner = ARB_SEND;
      2'b10:   o_winner = ARB_RECV;
      2'b11:   o_winner = (i_last_served == ARB_RECV) ? ARB_SEND : ARB_RECV;
      default: o_winner = ARB_IDLE;
    endcase
  end

endmodule

// File: rtl/ddma_mem_arbiter.sv
// Memory port arbiter between the SEND (read) and RECV (write) DMA engines.
// Defining DDMA_ARB_STATS_EN adds saturating per-engine beat counters.
module ddma_mem_arbiter
  import ddma_mem_arbiter_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int MAX_BURST        = ARB_MAX_BURST_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tx_req,
  input  logic                        tx_last,
  input  logic [MEMORY_BUS_WIDTH-1:0] tx_addr,
  output logic                        tx_gnt,
  output logic [MEMORY_BUS_WIDTH-1:0] tx_rdata,
  input  logic                        rx_req,
  input  logic                        rx_last,
  input  logic [MEMORY_BUS_WIDTH-1:0] rx_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0] rx_data,
  input  logic [3:0]                  rx_wb,
  output logic                        rx_gnt,
  output logic [MEMORY_BUS_WIDTH-1:0] addr_out,
  output logic [MEMORY_BUS_WIDTH-1:0] data_out,
  output logic [3:0]                  wb_out,
  input  logic [MEMORY_BUS_WIDTH-1:0] data_in,
  output arb_owner_t                  owner
`ifdef DDMA_ARB_STATS_EN
  ,
  output logic [31:0]                 tx_beat_cnt,
  output logic [31:0]                 rx_beat_cnt
`endif
);

  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

  arb_owner_t r_state;
  arb_owner_t w_next_state;
  arb_owner_t r_last_served;
  arb_owner_t w_next_last_served;
  arb_owner_t w_pick;
  logic [7:0] r_beat_cnt;
  logic [7:0] w_next_beat_cnt;
  logic [7:0] w_cnt_inc;
  logic       w_cur_req;
  logic       w_cur_last;

  rr_pick2 u_pick (
    .i_req         ({rx_req, tx_req}),
    .i_last_served (r_last_served),
    .o_winner      (w_pick)
  );

  assign w_cnt_inc = r_beat_cnt + 8'd1;

  // Request/last of whichever engine currently owns the port.
  always_comb begin
    w_cur_req  = 1'b0;
    w_cur_last = 1'b0;
    case (r_state)
      ARB_SEND: begin
        w_cur_req  = tx_req;
        w_cur_last = tx_last;
      end
      ARB_RECV: begin
        w_cur_req  = rx_req;
        w_cur_last = rx_last;
      end
      default: begin
        w_cur_req  = 1'b0;
        w_cur_last = 1'b0;
      end
    endcase
  end

  // Next-state, burst counter and release bookkeeping.
  always_comb begin
    w_next_state       = r_state;
    w_next_beat_cnt    = r_beat_cnt;
    w_next_last_served = r_last_served;
    case (r_state)
      ARB_IDLE: begin
        w_next_state    = w_pick;
        w_next_beat_cnt = 8'd0;
      end
      ARB_SEND, ARB_RECV: begin
        // Dropped request, final beat or full burst all hand the port back.
        if (!w_cur_req || w_cur_last || (w_cnt_inc == LP_MAX_BURST)) begin
          w_next_state       = ARB_IDLE;
          w_next_beat_cnt    = 8'd0;
          w_next_last_served = r_state;
        end else begin
          w_next_beat_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_next_state    = ARB_IDLE;
        w_next_beat_cnt = 8'd0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ARB_IDLE;
      r_beat_cnt    <= 8'd0;
      r_last_served <= ARB_SEND;
    end else begin
      r_state       <= w_next_state;
      r_beat_cnt    <= w_next_beat_cnt;
      r_last_served <= w_next_last_served;
    end
  end

  // Memory interface mux driven by the registered owner.
  always_comb begin
    addr_out = '0;
    data_out = '0;
    wb_out   = 4'd0;
    case (r_state)
      ARB_SEND: begin
        addr_out = tx_addr;
      end
      ARB_RECV: begin
        addr_out = rx_addr;
        data_out = rx_data;
        wb_out   = rx_wb;
      end
      default: begin
        addr_out = '0;
        data_out = '0;
        wb_out   = 4'd0;
      end
    endcase
  end

  assign tx_gnt   = (r_state == ARB_SEND);
  assign rx_gnt   = (r_state == ARB_RECV);
  assign owner    = r_state;
  assign tx_rdata = data_in;

`ifdef DDMA_ARB_STATS_EN
  logic [31:0] r_tx_beats;
  logic [31:0] r_rx_beats;

  // Saturating beat counters, one per engine.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_beats <= 32'd0;
      r_rx_beats <= 32'd0;
    end else begin
      if (tx_gnt && tx_req && (r_tx_beats != 32'hFFFF_FFFF)) begin
        r_tx_beats <= r_tx_beats + 32'd1;
      end
      if (rx_gnt && rx_req && (r_rx_beats != 32'hFFFF_FFFF)) begin
        r_rx_beats <= r_rx_beats + 32'd1;
      end
    end
  end

  assign tx_beat_cnt = r_tx_beats;
  assign rx_beat_cnt = r_rx_beats;
`endif

endmodule

// File: tb/tb_ddma_mem_arbiter.sv
// Randomized self-checking bench for ddma_mem_arbiter against a rule-level
// reference model; covers burst alternation, early release and async reset.
module tb_ddma_mem_arbiter;
  import ddma_mem_arbiter_pkg::*;

  localparam int TB_MAX_BURST = 4;

  logic        clock;
  logic        reset;
  logic        tx_req, tx_last, tx_gnt;
  logic [31:0] tx_addr, tx_rdata;
  logic        rx_req, rx_last, rx_gnt;
  logic [31:0] rx_addr, rx_data;
  logic [3:0]  rx_wb;
  logic [31:0] addr_out, data_out, data_in;
  logic [3:0]  wb_out;
  arb_owner_t  owner;
`ifdef DDMA_ARB_STATS_EN
  logic [31:0] tx_beat_cnt, rx_beat_cnt;
`endif

  ddma_mem_arbiter #(.MEMORY_BUS_WIDTH(32), .MAX_BURST(TB_MAX_BURST)) dut (
    .clock    (clock),
    .reset    (reset),
    .tx_req   (tx_req),
    .tx_last  (tx_last),
    .tx_addr  (tx_addr),
    .tx_gnt   (tx_gnt),
    .tx_rdata (tx_rdata),
    .rx_req   (rx_req),
    .rx_last  (rx_last),
    .rx_addr  (rx_addr),
    .rx_data  (rx_data),
    .rx_wb    (rx_wb),
    .rx_gnt   (rx_gnt),
    .addr_out (addr_out),
    .data_out (data_out),
    .wb_out   (wb_out),
    .data_in  (data_in),
    .owner    (owner)
`ifdef DDMA_ARB_STATS_EN
    ,
    .tx_beat_cnt (tx_beat_cnt),
    .rx_beat_cnt (rx_beat_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = SEND owns, 2 = RECV owns.
  int     m_owner;
  int     m_beats;
  int     m_last;
  longint m_tx_stat;
  longint m_rx_stat;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = 0;
    m_beats   = 0;
    m_last    = 1;
    m_tx_stat = 0;
    m_rx_stat = 0;
  endtask

  task automatic model_step();
    int req, lst;
    if (m_owner == 0) begin
      m_beats = 0;
      if (tx_req && rx_req) m_owner = (m_last == 1) ? 2 : 1;
      else if (tx_req)      m_owner = 1;
      else if (rx_req)      m_owner = 2;
      else                  m_owner = 0;
    end else begin
      req = (m_owner == 1) ? int'(tx_req) : int'(rx_req);
      lst = (m_owner == 1) ? int'(tx_last) : int'(rx_last);
      if (req == 0) begin
        m_last  = m_owner;
        m_owner = 0;
      end else begin
        m_beats++;
        if (m_owner == 1 && m_tx_stat < 64'hFFFF_FFFF) m_tx_stat++;
        if (m_owner == 2 && m_rx_stat < 64'hFFFF_FFFF) m_rx_stat++;
        if (lst != 0 || m_beats == TB_MAX_BURST) begin
          m_last  = m_owner;
          m_owner = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_wb;
    e_addr = (m_owner == 1) ? tx_addr : (m_owner == 2) ? rx_addr : 32'd0;
    e_data = (m_owner == 2) ? rx_data : 32'd0;
    e_wb   = (m_owner == 2) ? rx_wb : 4'd0;
    check_val("tx_gnt", 64'(tx_gnt), 64'(m_owner == 1));
    check_val("rx_gnt", 64'(rx_gnt), 64'(m_owner == 2));
    check_val("owner", 64'(owner), 64'(m_owner));
    check_val("addr_out", 64'(addr_out), 64'(e_addr));
    check_val("data_out", 64'(data_out), 64'(e_data));
    check_val("wb_out", 64'(wb_out), 64'(e_wb));
    check_val("tx_rdata", 64'(tx_rdata), 64'(data_in));
`ifdef DDMA_ARB_STATS_EN
    check_val("tx_beat_cnt", 64'(tx_beat_cnt), 64'(m_tx_stat));
    check_val("rx_beat_cnt", 64'(rx_beat_cnt), 64'(m_rx_stat));
`endif
  endtask

  // Called right after a falling edge; returns on the next falling edge.
  task automatic run_cycle();
    #1;
    check_outputs();
    model_step();
    @(negedge clock);
  endtask

  task automatic randomize_data();
    rx_data = $urandom;
    rx_wb   = 4'($urandom_range(0, 15));
    data_in = $urandom;
  endtask

  // Engine behaviour: hold request and address until granted.
  task automatic gen_random();
    if (m_owner == 1) begin
      tx_req  = ($urandom_range(0, 9) != 0);
      tx_last = ($urandom_range(0, 4) == 0);
      tx_addr = $urandom;
    end else if (!tx_req) begin
      tx_req  = ($urandom_range(0, 2) == 0);
      tx_last = 1'b0;
      tx_addr = $urandom;
    end else begin
      tx_last = 1'b0;
    end
    if (m_owner == 2) begin
      rx_req  = ($urandom_range(0, 9) != 0);
      rx_last = ($urandom_range(0, 4) == 0);
      rx_addr = $urandom;
    end else if (!rx_req) begin
      rx_req  = ($urandom_range(0, 2) == 0);
      rx_last = 1'b0;
      rx_addr = $urandom;
    end else begin
      rx_last = 1'b0;
    end
    randomize_data();
  endtask

  function automatic int pattern_owner(input int k);
    int p;
    if (k == 0) return 0;
    p = (k - 1) % 10;
    if (p < 4)  return 2;
    if (p == 4) return 0;
    if (p < 9)  return 1;
    return 0;
  endfunction

  initial begin
    int guard;
    clock   = 1'b0;
    reset   = 1'b0;
    tx_req  = 1'b0;
    tx_last = 1'b0;
    tx_addr = 32'd0;
    rx_req  = 1'b0;
    rx_last = 1'b0;
    rx_addr = 32'd0;
    rx_data = 32'd0;
    rx_wb   = 4'd0;
    data_in = 32'd0;
    model_reset();

    repeat (2) @(negedge clock);
    tx_req  = 1'b1;
    rx_req  = 1'b1;
    rx_wb   = 4'hF;
    rx_addr = 32'h1234_5678;
    tx_addr = 32'h8765_4321;
    #1;
    check_val("reset_tx_gnt", 64'(tx_gnt), 64'd0);
    check_val("reset_rx_gnt", 64'(rx_gnt), 64'd0);
    check_val("reset_addr", 64'(addr_out), 64'd0);
    check_val("reset_wb", 64'(wb_out), 64'd0);
    check_val("reset_owner", 64'(owner), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Continuous dual request, last never set: 4 RECV, idle, 4 SEND, idle.
    tx_last = 1'b0;
    rx_last = 1'b0;
    tx_addr = $urandom;
    rx_addr = $urandom;
    for (int k = 0; k < 31; k++) begin
      randomize_data();
      #1;
      check_val("pattern_owner", 64'(owner), 64'(pattern_owner(k)));
      check_outputs();
      model_step();
      @(negedge clock);
    end

    // Reset mid-RECV burst, then a tie must go to RECV again.
    guard = 0;
    while (!(m_owner == 2 && m_beats == 2) && guard < 40) begin
      randomize_data();
      run_cycle();
      guard++;
    end
    check_val("reach_recv_burst", 64'(guard < 40), 64'd1);
    rx_wb = 4'hA;
    reset = 1'b0;
    #1;
    check_val("midrst_rx_gnt", 64'(rx_gnt), 64'd0);
    check_val("midrst_wb", 64'(wb_out), 64'd0);
    check_val("midrst_addr", 64'(addr_out), 64'd0);
    model_reset();
    check_outputs();
    @(negedge clock);
    reset = 1'b1;
    run_cycle();
    #1;
    check_val("tie_after_reset", 64'(rx_gnt), 64'd1);
    @(negedge clock);
    model_step();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      gen_random();
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddma_mem_arbiter.md
Name: ddma_mem_arbiter

Overview:
- Shares the single memory port of the double DMA between its SEND engine (memory reads that feed the router) and its RECV engine (memory writes of flits arriving from the router).
- Grants are registered request/grant bursts with round-robin priority and a bounded burst length, so neither engine can starve the other.
- Drives the DMA's memory interface mux (address, write data, byte enables) and returns read data to the SEND engine.

Parameters:
- MEMORY_BUS_WIDTH, 32, width of memory address and data words.
- MAX_BURST, 16, maximum beats per grant before forced release; legal range is 1..255.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tx_req  in  1  SEND engine requests the memory port.
- tx_last  in  1  current SEND beat is the final beat of its transfer.
- tx_addr  in  MEMORY_BUS_WIDTH  SEND read address.
- tx_gnt  out  1  SEND owns the port this cycle.
- tx_rdata  out  MEMORY_BUS_WIDTH  read data returned to SEND (equals data_in).
- rx_req  in  1  RECV engine requests the memory port.
- rx_last  in  1  current RECV beat is the final beat.
- rx_addr  in  MEMORY_BUS_WIDTH  RECV write address.
- rx_data  in  MEMORY_BUS_WIDTH  RECV write data.
- rx_wb  in  4  RECV byte write enables.
- rx_gnt  out  1  RECV owns the port this cycle.
- addr_out  out  MEMORY_BUS_WIDTH  memory address.
- data_out  out  MEMORY_BUS_WIDTH  memory write data.
- wb_out  out  4  memory byte write enables; 0 means read.
- data_in  in  MEMORY_BUS_WIDTH  memory read data.
- owner  out  2  current owner, encoded as arb_owner_t.

Behaviour:
- States: ARB_IDLE, ARB_SEND, ARB_RECV.
- Reset (reset=0, asynchronous):
  - state=ARB_IDLE, beat count=0, last_served=ARB_SEND, so RECV wins the first tie.
  - tx_gnt, rx_gnt, addr_out, data_out and wb_out are all 0; owner=ARB_IDLE.
- Grant timing:
  - ARB_IDLE samples requests and moves to the winning state on the next edge.
  - The grant is visible one cycle after the request; minimum grant latency is 1 cycle.
- Arbitration in ARB_IDLE:
  - Only one request: that requester wins.
  - Both request: the requester that is not last_served wins.
  - Neither requests: stay in ARB_IDLE.
- Beats:
  - A beat is any cycle where gnt=1 and req=1.
  - The counter increments per beat and clears on entry to ARB_IDLE.
- Release, evaluated each granted cycle; the state returns to ARB_IDLE on the next edge when any of these hold:
  - a beat with last=1;
  - a beat that brings the count to MAX_BURST;
  - req=0 while granted (no beat counted).
  - On release, last_served is set to the releasing owner.
- Turnaround: ARB_IDLE always lasts at least one cycle between bursts, including a re-grant of the same requester. No back-to-back grants to different owners.
- Mux (combinational from state):
  - ARB_SEND: addr_out=tx_addr, wb_out=0, data_out=0.
  - ARB_RECV: addr_out=rx_addr, data_out=rx_data, wb_out=rx_wb.
  - ARB_IDLE: all three are 0.
- tx_rdata=data_in unconditionally. Memory read latency is the SEND engine's concern.
- Exactly one of tx_gnt/rx_gnt is 1 in a granted state; both are 0 in ARB_IDLE.
- Requesters must hold req and addr stable until they see their grant.
- rx_wb is ignored outside ARB_RECV.
- Reset asserted mid-burst: immediate return to reset values. The in-flight beat is lost and the engine restarts its transfer.
- MAX_BURST=1: every beat releases, giving strict alternation under continuous dual request.

Optional Feature:
- DDMA_ARB_STATS_EN defined: adds outputs tx_beat_cnt and rx_beat_cnt, each 32 bits.
  - Each counts beats granted to its engine and saturates at 0xFFFFFFFF.
  - Both clear on reset.
- Undefined: these ports and their counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package defs gains:
  - typedef enum logic[1:0] arb_owner_t, with ARB_IDLE=0, ARB_SEND=1, ARB_RECV=2;
  - constant ARB_MAX_BURST_DEFAULT=16.
- Existing defs::memword is used for the address and data ports.
- One sub-module: rr_pick2, a combinational two-way round-robin selector taking req[1:0] and last_served and returning the winner.

Test Plan:
- After reset, tx_req=1 and rx_req=1 at cycle 0 -> rx_gnt=1 at cycle 1; wb_out=rx_wb; addr_out=rx_addr.
- Continuous dual request, MAX_BURST=4, last never asserted -> 4 RECV beats, 1 idle cycle, 4 SEND beats, 1 idle cycle, repeating.
- SEND granted, tx_last=1 on beat 2 -> tx_gnt drops after beat 2; owner=ARB_IDLE for 1 cycle; rx_gnt=1 next if rx_req is pending.
- RECV granted, rx_req dropped mid-burst after 3 beats -> release with no beat counted that cycle; the stats build shows rx_beat_cnt=3.
- reset pulsed low mid-RECV burst -> the same cycle shows rx_gnt=0, wb_out=0, addr_out=0; after release, a tie is won by RECV.
- MAX_BURST=1 with both requesting -> gnt alternates RECV, idle, SEND, idle; wb_out is 0 on every SEND and idle cycle.
